// File: rtl/psum_accumulator_pkg.sv
// rtl/psum_accumulator_pkg.sv - shared widths, defaults and FSM state type for the psum accumulator
package psum_accumulator_pkg;

  localparam int PSUM_WIDTH    = 32;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_MAX_LEN   = 256;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_RUN,
    ACC_DONE
  } acc_state_e;

  // Beat counter must hold MAX_LEN itself, not just MAX_LEN-1.
  function automatic int count_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/psum_accumulator_sat_lane_add.sv
// rtl/psum_accumulator_sat_lane_add.sv - unsigned lane adder with carry in/out and optional saturation
module sat_lane_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  input  logic         sat_en_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  logic [W:0] raw;

  always_comb begin
    raw     = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
    carry_o = raw[W];
    sum_o   = (sat_en_i && raw[W]) ? '1 : raw[W-1:0];
  end

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - groups multiplier products into saturating partial sums, one or two lanes
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int MAX_LEN   = DEF_MAX_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PSUM_WIDTH-1:0]     in_prod,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_psum,
  output logic                      out_mode,
  output logic [$clog2(MAX_LEN):0]  out_count,
  output logic                      out_sat,
  output logic                      out_trunc
);

  localparam int HW = ACC_WIDTH / 2;
  localparam int PH = PSUM_WIDTH / 2;
  localparam int CW = count_width(MAX_LEN);

  acc_state_e           state_q, state_d;
  logic                 run_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 mode_q, mode_d;
  logic                 sat_q, sat_d;
  logic                 trunc_q, trunc_d;

  logic                 in_fire, out_fire, start, close, lane_mode, sat_now;
  logic [CW-1:0]        count_nxt;
  logic [ACC_WIDTH-1:0] base, operand, sum_new;
  logic [HW-1:0]        sum_lo, sum_hi;
  logic                 carry_lo, carry_hi;

  assign out_valid = (state_q == ACC_DONE);
  assign in_ready  = run_q && (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // A beat opens a new group from IDLE, or from DONE while the result is taken.
  assign start     = in_fire && (state_q != ACC_RUN);
  assign lane_mode = start ? mode : mode_q;
  assign count_nxt = start ? CW'(1) : count_q + CW'(1);
  assign close     = in_last || (count_nxt == CW'(MAX_LEN));

  assign base    = start ? '0 : acc_q;
  assign operand = lane_mode ? {HW'(in_prod[PSUM_WIDTH-1:PH]), HW'(in_prod[PH-1:0])}
                             : ACC_WIDTH'(in_prod);

  sat_lane_add #(.W(HW)) u_lane0 (
    .a_i      (base[HW-1:0]),
    .b_i      (operand[HW-1:0]),
    .cin_i    (1'b0),
    .sat_en_i (lane_mode),
    .sum_o    (sum_lo),
    .carry_o  (carry_lo)
  );

  // In mode 0 the low carry ripples up so both lanes act as one wide adder.
  sat_lane_add #(.W(HW)) u_lane1 (
    .a_i      (base[ACC_WIDTH-1:HW]),
    .b_i      (operand[ACC_WIDTH-1:HW]),
    .cin_i    (lane_mode ? 1'b0 : carry_lo),
    .sat_en_i (1'b1),
    .sum_o    (sum_hi),
    .carry_o  (carry_hi)
  );

  assign sum_new = (!lane_mode && carry_hi) ? '1 : {sum_hi, sum_lo};
  assign sat_now = (lane_mode && carry_lo) || carry_hi;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC_IDLE, ACC_RUN: begin
        if (in_fire) state_d = close ? ACC_DONE : ACC_RUN;
      end
      ACC_DONE: begin
        if (in_fire)       state_d = close ? ACC_DONE : ACC_RUN;
        else if (out_fire) state_d = ACC_IDLE;
      end
      default: state_d = ACC_IDLE;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    mode_d  = mode_q;
    sat_d   = sat_q;
    trunc_d = trunc_q;
    if (in_fire) begin
      acc_d   = sum_new;
      count_d = count_nxt;
      mode_d  = lane_mode;
      sat_d   = (sat_q && !start) || sat_now;
      trunc_d = close && !in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC_IDLE;
      run_q   <= 1'b0;
      acc_q   <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      sat_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      acc_q   <= acc_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      sat_q   <= sat_d;
      trunc_q <= trunc_d;
    end
  end

  assign out_psum  = acc_q;
  assign out_count = count_q;
  assign out_mode  = mode_q;
  assign out_sat   = sat_q;
  assign out_trunc = trunc_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - directed and randomized checks of psum_accumulator against a group-sum model
module tb_psum_accumulator;
  import psum_accumulator_pkg::*;

  localparam int AW  = 32;
  localparam int ML  = 256;
  localparam int ML4 = 4;
  localparam int CW  = $clog2(ML) + 1;
  localparam int CW4 = $clog2(ML4) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [PSUM_WIDTH-1:0] in_prod = '0;

  logic a_in_ready, a_out_valid, a_out_mode, a_out_sat, a_out_trunc;
  logic [AW-1:0] a_out_psum;
  logic [CW-1:0] a_out_count;
  logic b_in_ready, b_out_valid, b_out_mode, b_out_sat, b_out_trunc;
  logic [AW-1:0] b_out_psum;
  logic [CW4-1:0] b_out_count;

  psum_accumulator #(.ACC_WIDTH(AW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_psum(a_out_psum), .out_mode(a_out_mode), .out_count(a_out_count),
    .out_sat(a_out_sat), .out_trunc(a_out_trunc)
  );

  psum_accumulator #(.ACC_WIDTH(AW), .MAX_LEN(ML4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_psum(b_out_psum), .out_mode(b_out_mode), .out_count(b_out_count),
    .out_sat(b_out_sat), .out_trunc(b_out_trunc)
  );

  bit sel = 1'b0;
  logic c_in_ready, c_out_valid, c_out_mode, c_out_sat, c_out_trunc;
  logic [AW-1:0] c_out_psum;
  logic [CW-1:0] c_out_count;

  always_comb begin
    if (sel) begin
      c_in_ready = b_in_ready; c_out_valid = b_out_valid; c_out_mode = b_out_mode;
      c_out_sat = b_out_sat; c_out_trunc = b_out_trunc; c_out_psum = b_out_psum;
      c_out_count = CW'(b_out_count);
    end else begin
      c_in_ready = a_in_ready; c_out_valid = a_out_valid; c_out_mode = a_out_mode;
      c_out_sat = a_out_sat; c_out_trunc = a_out_trunc; c_out_psum = a_out_psum;
      c_out_count = a_out_count;
    end
  end

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [31:0] bt_prod[$];
  bit bt_last[$];
  bit bt_mode[$];
  int bt_gap[$];
  bit rdy_pat[$];
  bit rdy_rand = 1'b0;

  logic [AW-1:0] o_psum[$], e_psum[$];
  int o_count[$], e_count[$];
  bit o_mode[$], e_mode[$], o_sat[$], e_sat[$], o_trunc[$], e_trunc[$];
  int o_cyc[$], f_cyc[$];
  int hold_viol, rdy_viol, stall_cnt, wait_cnt;

  task automatic clear_beats();
    bt_prod.delete(); bt_last.delete(); bt_mode.delete(); bt_gap.delete(); rdy_pat.delete();
  endtask

  task automatic add_beat(input logic [31:0] p, input bit last, input bit md, input int gap);
    bt_prod.push_back(p); bt_last.push_back(last); bt_mode.push_back(md); bt_gap.push_back(gap);
  endtask

  // Reference: group sums from the beat list using wide integers and explicit clamping.
  task automatic model(input int max_len);
    longint unsigned s0, s1;
    bit open, gm, st;
    int cnt;
    open = 0; gm = 0; st = 0; cnt = 0; s0 = 0; s1 = 0;
    e_psum.delete(); e_count.delete(); e_mode.delete(); e_sat.delete(); e_trunc.delete();
    for (int i = 0; i < bt_prod.size(); i++) begin
      if (!open) begin
        open = 1; gm = bt_mode[i]; s0 = 0; s1 = 0; cnt = 0; st = 0;
      end
      cnt++;
      if (!gm) begin
        s0 = s0 + bt_prod[i];
        if (s0 > 64'hFFFF_FFFF) begin s0 = 64'hFFFF_FFFF; st = 1; end
      end else begin
        s0 = s0 + bt_prod[i][15:0];
        s1 = s1 + bt_prod[i][31:16];
        if (s0 > 64'hFFFF) begin s0 = 64'hFFFF; st = 1; end
        if (s1 > 64'hFFFF) begin s1 = 64'hFFFF; st = 1; end
      end
      if (bt_last[i] || cnt == max_len) begin
        e_psum.push_back(gm ? {s1[15:0], s0[15:0]} : s0[31:0]);
        e_count.push_back(cnt);
        e_mode.push_back(gm);
        e_sat.push_back(st);
        e_trunc.push_back(!bt_last[i] && cnt == max_len);
        open = 0;
      end
    end
  endtask

  task automatic run_stream(input int n_exp, input int budget, output bit to);
    bit drv_to, col_to, fired;
    drv_to = 0; col_to = 0; fired = 0;
    o_psum.delete(); o_count.delete(); o_mode.delete(); o_sat.delete(); o_trunc.delete();
    o_cyc.delete(); f_cyc.delete();
    hold_viol = 0; rdy_viol = 0; stall_cnt = 0; wait_cnt = 0;
    fork
      begin
        int k = 0;
        for (int i = 0; i < bt_prod.size() && !drv_to; i++) begin
          in_valid = 0; in_last = 0;
          repeat (bt_gap[i]) begin @(posedge clk); #1; end
          in_valid = 1; in_prod = bt_prod[i]; in_last = bt_last[i]; mode = bt_mode[i];
          fired = 0;
          while (!fired && !drv_to) begin
            @(negedge clk);
            if (c_in_ready) begin f_cyc.push_back(cyc); fired = 1; end
            @(posedge clk); #1;
            k++;
            if (k > budget) drv_to = 1;
          end
        end
        in_valid = 0; in_last = 0;
      end
      begin
        int k = 0;
        bit pv = 0;
        logic [AW-1:0] pp = '0;
        logic [CW-1:0] pc = '0;
        bit pm = 0, ps = 0, pt = 0;
        while (o_psum.size() < n_exp && !col_to) begin
          if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
          else if (rdy_rand) out_ready = ($urandom_range(0, 9) < 7);
          else out_ready = 1;
          @(negedge clk);
          if (pv && (!c_out_valid || c_out_psum !== pp || c_out_count !== pc ||
                     c_out_mode !== pm || c_out_sat !== ps || c_out_trunc !== pt)) hold_viol++;
          if (c_out_valid && !out_ready) begin
            wait_cnt++;
            if (c_in_ready) rdy_viol++;
          end
          if (in_valid && !c_in_ready) stall_cnt++;
          if (c_out_valid && out_ready) begin
            o_psum.push_back(c_out_psum); o_count.push_back(int'(c_out_count));
            o_mode.push_back(c_out_mode); o_sat.push_back(c_out_sat);
            o_trunc.push_back(c_out_trunc); o_cyc.push_back(cyc);
          end
          pv = c_out_valid && !out_ready;
          pp = c_out_psum; pc = c_out_count; pm = c_out_mode; ps = c_out_sat; pt = c_out_trunc;
          @(posedge clk); #1;
          k++;
          if (k > budget) col_to = 1;
        end
      end
    join
    out_ready = 1;
    to = drv_to || col_to;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    sel = 0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (c_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b want 0", c_in_ready); end
    total++; if (c_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b want 0", c_out_valid); end
    total++;
    if ({c_out_psum, c_out_count, c_out_mode, c_out_sat, c_out_trunc} !== '0) begin
      bad++; $display("FAIL rst_outputs: got psum=%0h count=%0d mode=%0b sat=%0b trunc=%0b want all 0",
                      c_out_psum, c_out_count, c_out_mode, c_out_sat, c_out_trunc);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    total++; if (c_in_ready !== 1'b0) begin bad++; $display("FAIL rst_drop_cycle: got %0b want 0", c_in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (c_in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise: got %0b want 1", c_in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_mode0();
    bit to;
    sel = 0; clear_beats();
    add_beat(32'd3825, 0, 0, 0); add_beat(32'd3825, 0, 0, 0); add_beat(32'd3825, 1, 0, 0);
    run_stream(1, 200, to);
    total++;
    if (to || o_psum.size() != 1) begin
      bad++; $display("FAIL m0_outputs: got %0d outputs timeout=%0b want 1", o_psum.size(), to);
    end else begin
      total++; if (o_psum[0] !== 32'd11475) begin bad++; $display("FAIL m0_psum: got %0d want 11475", o_psum[0]); end
      total++; if (o_count[0] != 3) begin bad++; $display("FAIL m0_count: got %0d want 3", o_count[0]); end
      total++; if (o_mode[0] !== 1'b0 || o_sat[0] !== 1'b0 || o_trunc[0] !== 1'b0) begin
        bad++; $display("FAIL m0_flags: got mode=%0b sat=%0b trunc=%0b want 0 0 0", o_mode[0], o_sat[0], o_trunc[0]);
      end
      total++; if (o_cyc[0] != f_cyc[2] + 1) begin
        bad++; $display("FAIL m0_latency: got cycle %0d want %0d", o_cyc[0], f_cyc[2] + 1);
      end
    end
  endtask

  task automatic test_mode1();
    bit to;
    sel = 0; clear_beats();
    add_beat({16'd3825, 16'd2}, 0, 1, 0); add_beat({16'd3825, 16'd2}, 1, 1, 0);
    run_stream(1, 200, to);
    total++;
    if (to || o_psum.size() != 1) begin
      bad++; $display("FAIL m1_outputs: got %0d outputs timeout=%0b want 1", o_psum.size(), to);
    end else begin
      total++; if (o_psum[0] !== {16'd7650, 16'd4}) begin bad++; $display("FAIL m1_psum: got %0h want %0h", o_psum[0], {16'd7650, 16'd4}); end
      total++; if (o_mode[0] !== 1'b1 || o_count[0] != 2) begin
        bad++; $display("FAIL m1_mode_count: got mode=%0b count=%0d want 1 2", o_mode[0], o_count[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    sel = 0; clear_beats();
    add_beat(32'd5, 1, 0, 0); add_beat(32'd7, 1, 0, 0);
    run_stream(2, 200, to);
    total++;
    if (to || o_psum.size() != 2) begin
      bad++; $display("FAIL b2b_outputs: got %0d outputs timeout=%0b want 2", o_psum.size(), to);
    end else begin
      total++; if (o_psum[0] !== 32'd5 || o_psum[1] !== 32'd7) begin
        bad++; $display("FAIL b2b_psum: got %0d,%0d want 5,7", o_psum[0], o_psum[1]);
      end
      total++; if (o_cyc[1] != o_cyc[0] + 1 || f_cyc[1] != f_cyc[0] + 1) begin
        bad++; $display("FAIL b2b_spacing: got out gap %0d in gap %0d want 1 1", o_cyc[1] - o_cyc[0], f_cyc[1] - f_cyc[0]);
      end
      total++; if (stall_cnt != 0) begin bad++; $display("FAIL b2b_in_ready: got %0d stalled cycles want 0", stall_cnt); end
    end
  endtask

  task automatic test_hold();
    bit to;
    logic [31:0] a, b, c;
    a = $urandom & 32'hFFFF; b = $urandom & 32'hFFFF; c = $urandom & 32'hFFFF;
    sel = 0; clear_beats();
    add_beat(a, 0, 0, 0); add_beat(b, 1, 0, 0); add_beat(c, 1, 0, 0);
    for (int i = 0; i < 6; i++) rdy_pat.push_back(i < 2);
    run_stream(2, 200, to);
    total++;
    if (to || o_psum.size() != 2) begin
      bad++; $display("FAIL hold_outputs: got %0d outputs timeout=%0b want 2", o_psum.size(), to);
    end else begin
      total++; if (o_psum[0] !== a + b || o_psum[1] !== c) begin
        bad++; $display("FAIL hold_psum: got %0d,%0d want %0d,%0d", o_psum[0], o_psum[1], a + b, c);
      end
      total++; if (wait_cnt != 4 || rdy_viol != 0) begin
        bad++; $display("FAIL hold_in_ready: got wait=%0d ready_while_blocked=%0d want 4 0", wait_cnt, rdy_viol);
      end
      total++; if (hold_viol != 0) begin bad++; $display("FAIL hold_stable: got %0d changes want 0", hold_viol); end
      total++; if (o_cyc[0] != f_cyc[1] + 5 || f_cyc[2] != o_cyc[0]) begin
        bad++; $display("FAIL hold_release: got out=%0d next_in=%0d want %0d %0d", o_cyc[0], f_cyc[2], f_cyc[1] + 5, f_cyc[1] + 5);
      end
    end
  endtask

  task automatic test_sat();
    bit to;
    sel = 0; clear_beats();
    for (int i = 0; i < 17; i++) add_beat({16'h0010, 16'h0FFF}, i == 16, 1, 0);
    add_beat(32'hFFFF_FFF0, 0, 0, 0); add_beat(32'h0000_0020, 1, 0, 0);
    add_beat(32'd3, 1, 0, 0);
    run_stream(3, 400, to);
    total++;
    if (to || o_psum.size() != 3) begin
      bad++; $display("FAIL sat_outputs: got %0d outputs timeout=%0b want 3", o_psum.size(), to);
    end else begin
      total++; if (o_psum[0] !== {16'd272, 16'hFFFF} || o_sat[0] !== 1'b1 || o_count[0] != 17) begin
        bad++; $display("FAIL sat_lane0: got psum=%0h sat=%0b count=%0d want %0h 1 17", o_psum[0], o_sat[0], o_count[0], {16'd272, 16'hFFFF});
      end
      total++; if (o_psum[1] !== 32'hFFFF_FFFF || o_sat[1] !== 1'b1) begin
        bad++; $display("FAIL sat_mode0: got psum=%0h sat=%0b want ffffffff 1", o_psum[1], o_sat[1]);
      end
      total++; if (o_psum[2] !== 32'd3 || o_sat[2] !== 1'b0) begin
        bad++; $display("FAIL sat_clear: got psum=%0h sat=%0b want 3 0", o_psum[2], o_sat[2]);
      end
    end
  endtask

  task automatic test_trunc();
    bit to;
    sel = 1; do_reset(); clear_beats();
    for (int i = 0; i < 6; i++) add_beat(32'd1, 0, 0, 0);
    run_stream(1, 200, to);
    total++;
    if (to || o_psum.size() != 1) begin
      bad++; $display("FAIL trunc_outputs: got %0d outputs timeout=%0b want 1", o_psum.size(), to);
    end else begin
      total++; if (o_psum[0] !== 32'd4 || o_count[0] != 4 || o_trunc[0] !== 1'b1) begin
        bad++; $display("FAIL trunc_group: got psum=%0d count=%0d trunc=%0b want 4 4 1", o_psum[0], o_count[0], o_trunc[0]);
      end
    end
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (c_in_ready !== 1'b0 || c_out_valid !== 1'b0) begin
        bad++; $display("FAIL trunc_in_rst: got in_ready=%0b out_valid=%0b want 0 0", c_in_ready, c_out_valid);
      end
    end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    clear_beats();
    add_beat(32'd9, 1, 0, 0);
    for (int i = 0; i < 4; i++) add_beat(32'd1, i == 3, 0, 0);
    run_stream(2, 200, to);
    total++;
    if (to || o_psum.size() != 2) begin
      bad++; $display("FAIL trunc_after_rst: got %0d outputs timeout=%0b want 2", o_psum.size(), to);
    end else begin
      total++; if (o_psum[0] !== 32'd9 || o_count[0] != 1) begin
        bad++; $display("FAIL trunc_discard: got psum=%0d count=%0d want 9 1", o_psum[0], o_count[0]);
      end
      total++; if (o_psum[1] !== 32'd4 || o_count[1] != 4 || o_trunc[1] !== 1'b0) begin
        bad++; $display("FAIL trunc_last_at_max: got psum=%0d count=%0d trunc=%0b want 4 4 0", o_psum[1], o_count[1], o_trunc[1]);
      end
    end
  endtask

  task automatic test_random(input bit s, input int max_len, input int ngroups);
    bit to;
    int len, gap;
    logic [31:0] p;
    sel = s; do_reset(); clear_beats();
    for (int g = 0; g < ngroups; g++) begin
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        case ($urandom_range(0, 2))
          0: p = $urandom & 32'h0000_0FFF;
          1: p = $urandom & 32'h3FFF_3FFF;
          default: p = $urandom;
        endcase
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        add_beat(p, j == len - 1, 1'($urandom_range(0, 1)), gap);
      end
    end
    model(max_len);
    rdy_rand = 1;
    run_stream(e_psum.size(), 4000, to);
    rdy_rand = 0;
    total++;
    if (to || o_psum.size() != e_psum.size()) begin
      bad++; $display("FAIL rand_outputs: got %0d outputs timeout=%0b want %0d", o_psum.size(), to, e_psum.size());
    end else begin
      for (int i = 0; i < e_psum.size(); i++) begin
        total++;
        if (o_psum[i] !== e_psum[i] || o_count[i] != e_count[i] || o_mode[i] !== e_mode[i] ||
            o_sat[i] !== e_sat[i] || o_trunc[i] !== e_trunc[i]) begin
          bad++;
          $display("FAIL rand_group[%0d] max=%0d: got psum=%0h cnt=%0d mode=%0b sat=%0b trunc=%0b want %0h %0d %0b %0b %0b",
                   i, max_len, o_psum[i], o_count[i], o_mode[i], o_sat[i], o_trunc[i],
                   e_psum[i], e_count[i], e_mode[i], e_sat[i], e_trunc[i]);
        end
      end
      total++; if (hold_viol != 0 || rdy_viol != 0) begin
        bad++; $display("FAIL rand_handshake: got hold=%0d ready_while_blocked=%0d want 0 0", hold_viol, rdy_viol);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_back_to_back();
    test_hold();
    test_sat();
    test_trunc();
    test_random(1'b1, ML4, 12);
    test_random(1'b0, ML, 12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
